// File: rtl/rom_dl_packer_if.sv
// Packed-write channel from rom_dl_packer to the DDR3 controller.
// The packer drives address, data, byte enables and a toggle request; ddram returns the toggle ack.
interface rom_dl_packer_if;
  logic [28:0] ddr_addr;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_be;
  logic        ddr_req;
  logic        ddr_ack;

  modport master (output ddr_addr, ddr_din, ddr_be, ddr_req, input ddr_ack);
  modport slave  (input ddr_addr, ddr_din, ddr_be, ddr_req, output ddr_ack);
endinterface

// File: rtl/rom_dl_packer.sv
// Write-combining stage: byte-swaps 16-bit ROM download words, packs four into one
// 64-bit DDR write and hands it to ddram over a toggle req/ack handshake.
module rom_dl_packer #(
  parameter int          ADDR_W   = 25,
  parameter logic [28:0] DDR_BASE = 29'h0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_wait,
  rom_dl_packer_if.master   ddr,
  output logic [23:0]       rom_size,
  output logic              dl_done
);

  localparam int QW = ADDR_W - 3;

  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-2:0] hold_widx_q, hold_widx_d;
  logic [15:0]       hold_data_q, hold_data_d;
  logic [63:0]       acc_q, acc_d;
  logic [7:0]        acc_be_q, acc_be_d;
  logic [QW-1:0]     acc_qaddr_q, acc_qaddr_d;
  logic              acc_full_q, acc_full_d;
  logic [28:0]       ddr_addr_q, ddr_addr_d;
  logic [63:0]       ddr_din_q, ddr_din_d;
  logic [7:0]        ddr_be_q, ddr_be_d;
  logic              ddr_req_q, ddr_req_d;
  logic [23:0]       rom_size_q, rom_size_d;
  logic              flush_q, flush_d;
  logic              dl_done_q, dl_done_d;
  logic              dl_active_q, dl_active_d;

  logic          rise, fall, flush_now, out_busy, acc_empty, qaddr_match;
  logic          commit, merge, done, capture;
  logic [QW-1:0] hold_qaddr;
  logic [1:0]    lane;
  logic [31:0]   size_cand;
  logic [23:0]   size_sat;

  // Byte address bit 0 is always zero on the ioctl bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = dl_addr[0];

  assign hold_qaddr = hold_widx_q[ADDR_W-2:2];
  assign lane       = hold_widx_q[1:0];

  // NOTE: every _d gets a default first, so no path through this block can infer a latch.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_widx_d = hold_widx_q;
    hold_data_d = hold_data_q;
    acc_d       = acc_q;
    acc_be_d    = acc_be_q;
    acc_qaddr_d = acc_qaddr_q;
    acc_full_d  = acc_full_q;
    ddr_addr_d  = ddr_addr_q;
    ddr_din_d   = ddr_din_q;
    ddr_be_d    = ddr_be_q;
    ddr_req_d   = ddr_req_q;
    rom_size_d  = rom_size_q;
    flush_d     = flush_q;
    dl_done_d   = 1'b0;
    dl_active_d = dl_active;

    rise        = dl_active & ~dl_active_q;
    fall        = ~dl_active & dl_active_q;
    flush_now   = flush_q | fall;
    out_busy    = ddr_req_q != ddr.ddr_ack;
    acc_empty   = acc_be_q == 8'h00;
    qaddr_match = hold_qaddr == acc_qaddr_q;

    // A commit frees the accumulator first; a blocked held word merges next cycle.
    commit  = ~rise & ~acc_empty & ~out_busy &
              (acc_full_q | (hold_v_q & ~qaddr_match) | (flush_now & ~hold_v_q));
    merge   = ~rise & hold_v_q & ~commit & (acc_empty | (qaddr_match & ~acc_full_q));
    done    = ~rise & flush_now & ~hold_v_q & acc_empty & ~out_busy;
    capture = dl_wr & dl_active & ~hold_v_q;

    size_cand = 32'(hold_widx_q) + 32'd1;
    size_sat  = (size_cand > 32'h00FF_FFFF) ? 24'hFF_FFFF : size_cand[23:0];

    if (rise) begin
      rom_size_d = '0;
      acc_d      = '0;
      acc_be_d   = '0;
      acc_full_d = 1'b0;
      hold_v_d   = 1'b0;
      flush_d    = 1'b0;
    end else begin
      flush_d   = flush_now & ~done;
      dl_done_d = done;
    end

    if (commit) begin
      ddr_din_d  = acc_q;
      ddr_be_d   = acc_be_q;
      ddr_addr_d = DDR_BASE + 29'(acc_qaddr_q);
      ddr_req_d  = ~ddr_req_q;
      acc_d      = '0;
      acc_be_d   = '0;
      acc_full_d = 1'b0;
    end

    if (merge) begin
      acc_d[{lane, 4'b0000} +: 16] = {hold_data_q[7:0], hold_data_q[15:8]};
      acc_be_d[{lane, 1'b0} +: 2]  = 2'b11;
      acc_qaddr_d                  = hold_qaddr;
      if (lane == 2'd3) acc_full_d = 1'b1;
      if (size_sat > rom_size_q) rom_size_d = size_sat;
      hold_v_d = 1'b0;
    end

    if (capture) begin
      hold_v_d    = 1'b1;
      hold_widx_d = dl_addr[ADDR_W-1:1];
      hold_data_d = dl_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_v_q    <= 1'b0;
      hold_widx_q <= '0;
      hold_data_q <= '0;
      acc_q       <= '0;
      acc_be_q    <= '0;
      acc_qaddr_q <= '0;
      acc_full_q  <= 1'b0;
      ddr_addr_q  <= '0;
      ddr_din_q   <= '0;
      ddr_be_q    <= '0;
      ddr_req_q   <= 1'b0;
      rom_size_q  <= '0;
      flush_q     <= 1'b0;
      dl_done_q   <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_widx_q <= hold_widx_d;
      hold_data_q <= hold_data_d;
      acc_q       <= acc_d;
      acc_be_q    <= acc_be_d;
      acc_qaddr_q <= acc_qaddr_d;
      acc_full_q  <= acc_full_d;
      ddr_addr_q  <= ddr_addr_d;
      ddr_din_q   <= ddr_din_d;
      ddr_be_q    <= ddr_be_d;
      ddr_req_q   <= ddr_req_d;
      rom_size_q  <= rom_size_d;
      flush_q     <= flush_d;
      dl_done_q   <= dl_done_d;
      dl_active_q <= dl_active_d;
    end
  end

  assign dl_wait      = hold_v_q;
  assign ddr.ddr_addr = ddr_addr_q;
  assign ddr.ddr_din  = ddr_din_q;
  assign ddr.ddr_be   = ddr_be_q;
  assign ddr.ddr_req  = ddr_req_q;
  assign rom_size     = rom_size_q;
  assign dl_done      = dl_done_q;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Self-checking bench for rom_dl_packer: directed table, corner-case sequences and
// randomized downloads checked against a run-based model of the packed DDR writes.
module tb_rom_dl_packer;
  localparam int          ADDR_W = 25;
  localparam logic [28:0] DB     = 29'h0100_0000;

  logic              clk_sys   = 1'b0;
  logic              reset_n   = 1'b0;
  logic              dl_active = 1'b0;
  logic              dl_wr     = 1'b0;
  logic [ADDR_W-1:0] dl_addr   = '0;
  logic [15:0]       dl_data   = '0;
  logic              dl_wait, dl_done;
  logic [23:0]       rom_size;

  rom_dl_packer_if ddr_if ();

  rom_dl_packer #(.ADDR_W(ADDR_W), .DDR_BASE(DB)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .dl_active(dl_active),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .ddr      (ddr_if),
    .rom_size (rom_size),
    .dl_done  (dl_done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [28:0]       exp_addr;
    logic [63:0]       exp_din;
    logic [7:0]        exp_be;
    logic [23:0]       exp_rom;
  } vec_t;

  wr_t               got_q[$];
  wr_t               exp_q[$];
  logic [ADDR_W-1:0] w_addr[$];
  logic [15:0]       w_data[$];

  int n_checks = 0, n_errs = 0;
  int cyc = 0, ack_delay = 1, last_ack_cyc = 0, fall_cyc = 0;
  int done_cnt = 0, done_cyc = 0, wait_cycles = 0, wait_run = 0, wait_run_max = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // ddram stand-in: acks each request after ack_delay cycles and logs the write.
  initial begin : ddram
    int  cnt;
    wr_t w;
    cnt = 0;
    ddr_if.ddr_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #2;
      if (!reset_n) begin
        ddr_if.ddr_ack = 1'b0;
        cnt = 0;
      end else if (ddr_if.ddr_req != ddr_if.ddr_ack) begin
        cnt++;
        if (cnt >= ack_delay) begin
          w.addr = ddr_if.ddr_addr;
          w.din  = ddr_if.ddr_din;
          w.be   = ddr_if.ddr_be;
          got_q.push_back(w);
          ddr_if.ddr_ack = ddr_if.ddr_req;
          last_ack_cyc = cyc;
          cnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk_sys); #3;
      if (dl_wait) begin
        wait_cycles++;
        wait_run++;
        if (wait_run > wait_run_max) wait_run_max = wait_run;
      end else begin
        wait_run = 0;
      end
      if (dl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errs);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    int n = 0;
    while (dl_wait && n < 500) begin
      tick();
      n++;
    end
    if (dl_wait) begin
      n_checks++;
      n_errs++;
      $display("FAIL send_word: dl_wait stuck got 1 expected 0");
    end else begin
      dl_addr = a;
      dl_data = d;
      dl_wr   = 1'b1;
      tick();
      dl_wr   = 1'b0;
    end
  endtask

  // Expected writes: words form runs; a run closes when the qword changes or after a
  // lane-3 word, and whatever is open at the end of the download is flushed.
  function automatic void build_exp();
    logic              open;
    wr_t               cur;
    logic [ADDR_W-4:0] cq, q;
    int                ln;
    exp_q.delete();
    open = 1'b0;
    cur  = '0;
    cq   = '0;
    for (int i = 0; i < w_addr.size(); i++) begin
      q  = w_addr[i][ADDR_W-1:3];
      ln = int'(w_addr[i][2:1]);
      if (open && q != cq) begin
        exp_q.push_back(cur);
        open = 1'b0;
      end
      if (!open) begin
        cur.addr = DB + 29'(q);
        cur.din  = '0;
        cur.be   = '0;
        cq       = q;
        open     = 1'b1;
      end
      cur.din[ln*16 +: 16] = {w_data[i][7:0], w_data[i][15:8]};
      cur.be[ln*2 +: 2]    = 2'b11;
      if (ln == 3) begin
        exp_q.push_back(cur);
        open = 1'b0;
      end
    end
    if (open) exp_q.push_back(cur);
  endfunction

  function automatic logic [23:0] exp_rom_size();
    longint m = 0;
    for (int i = 0; i < w_addr.size(); i++)
      if (longint'(w_addr[i][ADDR_W-1:1]) + 1 > m) m = longint'(w_addr[i][ADDR_W-1:1]) + 1;
    return (m > 64'h00FF_FFFF) ? 24'hFF_FFFF : m[23:0];
  endfunction

  // One complete download of w_addr/w_data; optional illegal strobe after word inj_after.
  task automatic run_dl(input string tag, input int inj_after,
                        input logic [ADDR_W-1:0] inj_a, input logic [15:0] inj_d);
    int n = 0;
    got_q.delete();
    done_cnt = 0; wait_cycles = 0; wait_run_max = 0;
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < w_addr.size(); i++) begin
      send_word(w_addr[i], w_data[i]);
      if (i == inj_after) begin
        check({tag, "_inject_wait"}, 64'(dl_wait), 64'd1);
        dl_addr = inj_a; dl_data = inj_d; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
      end
    end
    dl_active = 1'b0;
    fall_cyc  = cyc;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s_done_timeout: dl_done got 0 expected 1", tag);
    end
    repeat (5) tick();
    build_exp();
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_w%0d_addr", tag, i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_w%0d_din", tag, i), got_q[i].din, exp_q[i].din);
      check($sformatf("%s_w%0d_be", tag, i), 64'(got_q[i].be), 64'(exp_q[i].be));
    end
    check({tag, "_rom_size"}, 64'(rom_size), 64'(exp_rom_size()));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  vec_t vecs[7];

  initial begin : main
    vecs[0] = '{25'h0000000, 16'h1234, DB + 29'h0,      64'h0000_0000_0000_3412, 8'h03, 24'h000001};
    vecs[1] = '{25'h0000002, 16'hABCD, DB + 29'h0,      64'h0000_0000_CDAB_0000, 8'h0C, 24'h000002};
    vecs[2] = '{25'h0000004, 16'h00FF, DB + 29'h0,      64'h0000_FF00_0000_0000, 8'h30, 24'h000003};
    vecs[3] = '{25'h000000E, 16'hBEEF, DB + 29'h1,      64'hEFBE_0000_0000_0000, 8'hC0, 24'h000008};
    vecs[4] = '{25'h001FFFE, 16'h5A5A, DB + 29'h3FFF,   64'h5A5A_0000_0000_0000, 8'hC0, 24'h010000};
    vecs[5] = '{25'h1FFFFFE, 16'h0102, DB + 29'h3FFFFF, 64'h0201_0000_0000_0000, 8'hC0, 24'hFFFFFF};
    vecs[6] = '{25'h0000022, 16'h8001, DB + 29'h4,      64'h0000_0000_0180_0000, 8'h0C, 24'h000012};

    repeat (3) tick();
    check("reset_dl_wait", 64'(dl_wait), 64'd0);
    check("reset_ddr_req", 64'(ddr_if.ddr_req), 64'd0);
    check("reset_ddr_be", 64'(ddr_if.ddr_be), 64'd0);
    check("reset_rom_size", 64'(rom_size), 64'd0);
    check("reset_dl_done", 64'(dl_done), 64'd0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      w_addr = {vecs[i].addr};
      w_data = {vecs[i].data};
      run_dl($sformatf("vec%0d", i), -1, '0, '0);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_tbl_addr", i), 64'(got_q[0].addr), 64'(vecs[i].exp_addr));
        check($sformatf("vec%0d_tbl_din", i), got_q[0].din, vecs[i].exp_din);
        check($sformatf("vec%0d_tbl_be", i), 64'(got_q[0].be), 64'(vecs[i].exp_be));
      end
      check($sformatf("vec%0d_tbl_rom", i), 64'(rom_size), 64'(vecs[i].exp_rom));
    end

    // Four sequential words pack into one full write.
    w_addr = {25'h0, 25'h2, 25'h4, 25'h6};
    w_data = {16'h1122, 16'h3344, 16'h5566, 16'h7788};
    run_dl("seq4", -1, '0, '0);
    if (got_q.size() > 0) begin
      check("seq4_din", got_q[0].din, 64'h8877_6655_4433_2211);
      check("seq4_be", 64'(got_q[0].be), 64'hFF);
      check("seq4_addr", 64'(got_q[0].addr), 64'(DB));
    end
    check("seq4_wait_cycles", 64'(wait_cycles), 64'd4);

    // Empty download: dl_done on the cycle after the falling edge.
    w_addr.delete(); w_data.delete();
    run_dl("empty", -1, '0, '0);
    check("empty_done_latency", 64'(done_cyc - fall_cyc), 64'd1);

    // Twelve words with a slow ddram: the host is held off while stalled.
    ack_delay = 50;
    w_addr.delete(); w_data.delete();
    for (int i = 0; i < 12; i++) begin
      w_addr.push_back(ADDR_W'(i * 2));
      w_data.push_back(16'(16'hC000 + i * 16'h0111));
    end
    run_dl("stall12", -1, '0, '0);
    check("stall12_wait_held", 64'(wait_run_max >= 30), 64'd1);
    ack_delay = 1;

    // Five words then end of download: partial final write.
    w_addr = {25'h0, 25'h2, 25'h4, 25'h6, 25'h8};
    w_data = {16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213};
    run_dl("part5", -1, '0, '0);
    if (got_q.size() > 1) begin
      check("part5_be", 64'(got_q[1].be), 64'h03);
      check("part5_addr", 64'(got_q[1].addr), 64'(DB + 29'h1));
    end
    check("part5_rom", 64'(rom_size), 64'd5);
    check("part5_done_after_ack", 64'(done_cyc > last_ack_cyc), 64'd1);

    // Jump to a distant qword.
    w_addr = {25'h0, 25'h100};
    w_data = {16'h4142, 16'h4344};
    run_dl("jump", -1, '0, '0);
    if (got_q.size() > 1) begin
      check("jump_addr1", 64'(got_q[1].addr), 64'(DB + 29'h20));
      check("jump_be1", 64'(got_q[1].be), 64'h03);
    end

    // Strobe while dl_wait is high is ignored; last word at 'h1FFFE.
    w_addr = {25'h0, 25'h1FFFE};
    w_data = {16'hA1A2, 16'hC1C2};
    run_dl("ignore", 0, 25'h2, 16'hB1B2);
    if (got_q.size() > 0) check("ignore_din0", got_q[0].din, 64'h0000_0000_0000_A2A1);
    check("ignore_rom", 64'(rom_size), 64'h10000);

    // Randomized downloads.
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = int'($urandom_range(1, 16));
      ack_delay = int'($urandom_range(1, 6));
      w_addr.delete(); w_data.delete();
      for (int i = 0; i < nw; i++) begin
        w_addr.push_back(ADDR_W'($urandom_range(0, 15) * 2));
        w_data.push_back(16'($urandom));
      end
      run_dl($sformatf("rnd%0d", r), -1, '0, '0);
    end
    ack_delay = 1;

    // Reset while a write is pending and a word is held.
    got_q.delete();
    ack_delay = 100;
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) send_word(ADDR_W'(i * 2), 16'(16'hA000 + i));
    tick(); tick();
    check("rst_pre_wait", 64'(dl_wait), 64'd1);
    check("rst_pre_busy", 64'(ddr_if.ddr_req ^ ddr_if.ddr_ack), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_dl_wait", 64'(dl_wait), 64'd0);
    check("rst_ddr_req", 64'(ddr_if.ddr_req), 64'd0);
    check("rst_ddr_addr", 64'(ddr_if.ddr_addr), 64'd0);
    check("rst_ddr_din", ddr_if.ddr_din, 64'd0);
    check("rst_ddr_be", 64'(ddr_if.ddr_be), 64'd0);
    check("rst_rom_size", 64'(rom_size), 64'd0);
    check("rst_dl_done", 64'(dl_done), 64'd0);
    dl_active = 1'b0;
    ack_delay = 1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    w_addr = {25'h0, 25'h2, 25'h4, 25'h6};
    w_data = {16'h0102, 16'h0304, 16'h0506, 16'h0708};
    run_dl("post_rst", -1, '0, '0);
    if (got_q.size() > 0) check("post_rst_din", got_q[0].din, 64'h0807_0605_0403_0201);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_dl_packer.md
Name: rom_dl_packer

Overview:
- Write-combining stage between the HPS ROM download stream (16-bit ioctl words) and the DDR3 cartridge store.
- Byte-swaps each word and packs four consecutive words into one 64-bit DDR write with byte enables.
- Hands each packed write to ddram over a toggle req/ack handshake.
- Throttles the host with dl_wait; reports final ROM size in words for the system ROMSZ input.

Parameters:
- ADDR_W, 25: width of the download byte address.
- DDR_BASE, 29'h0: qword base of the ROM region in DDR, added to every write address.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  one-cycle word strobe.
- dl_addr  in  ADDR_W  byte address; bit 0 is always 0.
- dl_data  in  16  word in host byte order.
- dl_wait  out  1  host must not strobe dl_wr while this is high.
- ddr_addr  out  29  qword write address.
- ddr_din  out  64  write data.
- ddr_be  out  8  byte enables.
- ddr_req  out  1  toggles once per write request.
- ddr_ack  in  1  ddram sets this equal to ddr_req when the write is done.
- rom_size  out  24  highest word index written + 1.
- dl_done  out  1  one-cycle pulse when the final flush is complete.

Behaviour:
- Reset (async, reset_n=0): all state and outputs are 0, including hold_v, acc_be, acc_full, ddr_req and dl_wait.
- Stage 1, hold register:
  - dl_wr with dl_active=1 and hold_v=0 captures addr and data; hold_v is set next cycle.
  - dl_wr while hold_v=1 or dl_active=0 is ignored.
  - dl_wait = hold_v (registered).
- Stage 2, accumulator (acc, acc_be, acc_qaddr = addr[ADDR_W-1:3], acc_full):
  - Merge of hold into acc happens when acc_be==0, or when hold qaddr==acc_qaddr and acc_full=0.
  - Lane = addr[2:1]. Data {d[7:0],d[15:8]} is written to acc[lane*16+:16]; acc_be[lane*2+:2] is set; hold_v is cleared.
  - A merge into lane 3 sets acc_full.
  - On merge, rom_size <= max(rom_size, addr[ADDR_W-1:1]+1).
- Stage 3, out:
  - out_busy = (ddr_req != ddr_ack).
  - Commit happens when acc_be!=0, out_busy=0, and one of:
    - acc_full;
    - hold_v with a mismatched qaddr;
    - flush pending with hold_v=0.
  - On commit: ddr_din<=acc, ddr_be<=acc_be, ddr_addr<=DDR_BASE+acc_qaddr; ddr_req toggles; acc_be, acc and acc_full are cleared.
  - Commit has priority over merge in the same cycle. The held word merges on the following cycle.
- Latency: with no stall, dl_wait is high for exactly 1 cycle per word. A write whose commit waits on out_busy holds dl_wait high until ddr_ack matches ddr_req and the merge completes.
- Download start (rising edge of dl_active):
  - rom_size, acc_be, acc_full, hold_v and flush are cleared.
  - ddr_req keeps its parity. A pending write from before still completes normally.
- Download end (falling edge of dl_active):
  - flush is set.
  - The held word drains, then a partial acc commits with partial ddr_be.
  - dl_done pulses one cycle after hold_v=0, acc_be=0 and out_busy=0 all hold with flush set; flush clears at the pulse.
  - If nothing was written, dl_done pulses on the cycle after the falling edge.
- Non-sequential addresses are legal; each distinct qword produces its own write.
- A re-write of an already-set lane within the current qword overwrites the data.
- ddr_req/ddr_ack must share the reset domain with ddram. Reset mid-transfer drops the pending write and all buffered data.
- rom_size saturates at 24 bits; no wrap.

Test Plan:
- Sequential words 16'h1122, 3344, 5566, 7788 at addr 0, 2, 4, 6 → one ddr_req toggle; ddr_din = 64'h8877_6655_4433_2211; ddr_be = 8'hFF; ddr_addr = DDR_BASE; dl_wait high 1 cycle per word.
- 12 sequential words, ddr_ack withheld 50 cycles → dl_wait stays high while stalled; 3 writes at qaddr 0, 1, 2 with all data intact; no write lost or duplicated.
- 5 words at addr 0..8, then dl_active falls → second write has ddr_be = 8'h03 at qaddr 1; dl_done pulses once after the final ack; rom_size = 5.
- Word at addr 0, then word at addr 'h100 → two writes: qaddr 0 with be 8'h03, then qaddr 'h20 with be 8'h03.
- reset_n low while ddr_req != ddr_ack and hold_v = 1 → all outputs 0 immediately; after release, a new download starts cleanly.
- Last word written at addr 'h1FFFE → rom_size = 24'h10000; a strobe while dl_wait = 1 is ignored (data unchanged).
